// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST controller.
// The table is bit-indexed by element number (E0 = bit 0).
package sram_bist_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } bist_state_t;

   localparam int ERR_CNT_W = 8;
   localparam int ELEM_W    = 3;
   localparam logic [ELEM_W-1:0] LAST_ELEM = 3'd5;

   // E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 dn r0,w1 | E4 dn r1,w0 | E5 up r0
   localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
   localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
   localparam logic [7:0] ELEM_HAS_RD  = 8'b0011_1110;
   localparam logic [7:0] ELEM_RD_ONE  = 8'b0001_0100;
   localparam logic [7:0] ELEM_WR_ONE  = 8'b0000_1010;

   // Op 0 is the read when the element has one; op 1 is always the write.
   function automatic logic elem_op_is_rd(input logic [ELEM_W-1:0] e, input logic op);
      return ELEM_HAS_RD[e] && !op;
   endfunction

   function automatic logic elem_op_data(input logic [ELEM_W-1:0] e, input logic op);
      return elem_op_is_rd(e, op) ? ELEM_RD_ONE[e] : ELEM_WR_ONE[e];
   endfunction

endpackage

// File: rtl/sram_bist_chk.sv
// Read-expectation pipe and comparator: matches each read against A_DOUT
// P_RD_LAT cycles later, captures the first miscompare and counts the rest.
module sram_bist_chk
   import sram_bist_pkg::*;
#(
   parameter int P_ADDR_WIDTH = 10,
   parameter int P_DATA_WIDTH = 8,
   parameter int P_RD_LAT     = 1
) (
   input  logic                    A_CLK,
   input  logic                    A_RESET_N,
   input  logic                    clr,
   input  logic                    rd_vld,
   input  logic [P_DATA_WIDTH-1:0] rd_exp,
   input  logic [P_ADDR_WIDTH-1:0] rd_addr,
   input  logic [ELEM_W-1:0]       rd_elem,
   input  logic [P_DATA_WIDTH-1:0] rd_data,
   output logic                    fail,
   output logic [P_ADDR_WIDTH-1:0] fail_addr,
   output logic [ELEM_W-1:0]       fail_elem,
   output logic [P_DATA_WIDTH-1:0] fail_bits,
   output logic [ERR_CNT_W-1:0]    err_cnt
);

   typedef struct packed {
      logic                    vld;
      logic [P_DATA_WIDTH-1:0] exp;
      logic [P_ADDR_WIDTH-1:0] addr;
      logic [ELEM_W-1:0]       elem;
   } chk_ent_t;

   chk_ent_t pipe_reg [P_RD_LAT];
   chk_ent_t head_ent;
   chk_ent_t tail_ent;
   logic     miscmp;

   logic                    fail_reg;
   logic [P_ADDR_WIDTH-1:0] fail_addr_reg;
   logic [ELEM_W-1:0]       fail_elem_reg;
   logic [P_DATA_WIDTH-1:0] fail_bits_reg;
   logic [ERR_CNT_W-1:0]    err_cnt_reg;

   assign head_ent = {rd_vld, rd_exp, rd_addr, rd_elem};

   genvar gi;
   generate
      for (gi = 0; gi < P_RD_LAT; gi++) begin : g_pipe
         if (gi == 0) begin : g_head
            always_ff @(posedge A_CLK or negedge A_RESET_N) begin
               if (!A_RESET_N) pipe_reg[gi] <= '0;
               else            pipe_reg[gi] <= head_ent;
            end
         end else begin : g_tail
            always_ff @(posedge A_CLK or negedge A_RESET_N) begin
               if (!A_RESET_N) pipe_reg[gi] <= '0;
               else            pipe_reg[gi] <= pipe_reg[gi-1];
            end
         end
      end
   endgenerate

   assign tail_ent = pipe_reg[P_RD_LAT-1];
   // Case inequality so an undriven or X read word is reported as a failure.
   assign miscmp   = tail_ent.vld && (rd_data !== tail_ent.exp);

   always_ff @(posedge A_CLK or negedge A_RESET_N) begin
      if (!A_RESET_N) begin
         fail_reg      <= 1'b0;
         fail_addr_reg <= '0;
         fail_elem_reg <= '0;
         fail_bits_reg <= '0;
         err_cnt_reg   <= '0;
      end else if (clr) begin
         fail_reg      <= 1'b0;
         fail_addr_reg <= '0;
         fail_elem_reg <= '0;
         fail_bits_reg <= '0;
         err_cnt_reg   <= '0;
      end else if (miscmp) begin
         if (!fail_reg) begin
            fail_addr_reg <= tail_ent.addr;
            fail_elem_reg <= tail_ent.elem;
            fail_bits_reg <= rd_data ^ tail_ent.exp;
         end
         fail_reg <= 1'b1;
         if (err_cnt_reg != {ERR_CNT_W{1'b1}}) err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
      end
   end

   assign fail      = fail_reg;
   assign fail_addr = fail_addr_reg;
   assign fail_elem = fail_elem_reg;
   assign fail_bits = fail_bits_reg;
   assign err_cnt   = err_cnt_reg;

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer for a 1P SRAM BIST port: walks elements and
// addresses one command per cycle, then drains the read pipe before DONE.
module sram_march_bist_ctrl
   import sram_bist_pkg::*;
#(
   parameter int P_ADDR_WIDTH = 10,
   parameter int P_DATA_WIDTH = 8,
   parameter int P_RD_LAT     = 1
) (
   input  logic                    A_CLK,
   input  logic                    A_RESET_N,
   input  logic                    A_START,
   output logic                    A_BUSY,
   output logic                    A_DONE,
   output logic                    A_FAIL,
   output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
   output logic [ELEM_W-1:0]       A_FAIL_ELEM,
   output logic [P_DATA_WIDTH-1:0] A_FAIL_BITS,
   output logic [ERR_CNT_W-1:0]    A_ERR_CNT,
   output logic                    A_BIST_EN,
   output logic                    A_BIST_MEN,
   output logic                    A_BIST_WEN,
   output logic                    A_BIST_REN,
   output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
   output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
   output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
   input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

   localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX   = '1;
   localparam logic [1:0]              DRAIN_LAST = 2'(P_RD_LAT - 1);

   bist_state_t             state_reg;
   logic [ELEM_W-1:0]       elem_reg;
   logic                    op_reg;
   logic [1:0]              drain_cnt_reg;
   logic                    busy_reg;
   logic                    done_reg;
   logic                    en_reg;
   logic                    wen_reg;
   logic                    ren_reg;
   logic [P_ADDR_WIDTH-1:0] addr_reg;
   logic [P_DATA_WIDTH-1:0] din_reg;
   logic [P_DATA_WIDTH-1:0] bm_reg;

   logic                    go;
   logic                    op_last;
   logic                    addr_last;
   logic                    run_last;
   logic                    reload;
   logic [ELEM_W-1:0]       elem_next;
   logic [P_ADDR_WIDTH-1:0] addr_next;
   logic                    op_next;
   logic [ELEM_W-1:0]       sel_elem;
   logic [P_ADDR_WIDTH-1:0] sel_addr;
   logic                    sel_op;
   logic                    sel_rd;
   logic [P_DATA_WIDTH-1:0] sel_data;

   assign go = A_START && (state_reg == IDLE || state_reg == DONE);

   // Next position in the march; sel_* is what the command registers load.
   always_comb begin
      op_last   = !ELEM_TWO_OPS[elem_reg] || op_reg;
      addr_last = ELEM_DOWN[elem_reg] ? (addr_reg == '0) : (addr_reg == ADDR_MAX);
      run_last  = op_last && addr_last && (elem_reg == LAST_ELEM);
      elem_next = elem_reg;
      addr_next = addr_reg;
      op_next   = 1'b0;
      reload    = 1'b0;
      if (!op_last) begin
         op_next = 1'b1;
      end else if (!addr_last) begin
         addr_next = ELEM_DOWN[elem_reg] ? addr_reg - P_ADDR_WIDTH'(1)
                                         : addr_reg + P_ADDR_WIDTH'(1);
      end else begin
         elem_next = elem_reg + ELEM_W'(1);
         reload    = 1'b1;
      end
      if (reload) addr_next = ELEM_DOWN[elem_next] ? ADDR_MAX : '0;

      sel_elem = go ? '0 : elem_next;
      sel_addr = go ? '0 : addr_next;
      sel_op   = go ? 1'b0 : op_next;
      sel_rd   = elem_op_is_rd(sel_elem, sel_op);
      sel_data = {P_DATA_WIDTH{elem_op_data(sel_elem, sel_op)}};
   end

   always_ff @(posedge A_CLK or negedge A_RESET_N) begin
      if (!A_RESET_N) begin
         state_reg     <= IDLE;
         elem_reg      <= '0;
         op_reg        <= 1'b0;
         drain_cnt_reg <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         en_reg        <= 1'b0;
         wen_reg       <= 1'b0;
         ren_reg       <= 1'b0;
         addr_reg      <= '0;
         din_reg       <= '0;
         bm_reg        <= '0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (A_START) begin
                  state_reg <= RUN;
                  busy_reg  <= 1'b1;
                  done_reg  <= 1'b0;
                  en_reg    <= 1'b1;
                  bm_reg    <= '1;
                  elem_reg  <= sel_elem;
                  op_reg    <= sel_op;
                  addr_reg  <= sel_addr;
                  wen_reg   <= !sel_rd;
                  ren_reg   <= sel_rd;
                  din_reg   <= sel_data;
               end
            end
            RUN: begin
               if (run_last) begin
                  state_reg     <= DRAIN;
                  drain_cnt_reg <= '0;
                  wen_reg       <= 1'b0;
                  ren_reg       <= 1'b0;
                  addr_reg      <= '0;
                  din_reg       <= '0;
               end else begin
                  elem_reg <= sel_elem;
                  op_reg   <= sel_op;
                  addr_reg <= sel_addr;
                  wen_reg  <= !sel_rd;
                  ren_reg  <= sel_rd;
                  din_reg  <= sel_data;
               end
            end
            DRAIN: begin
               // Hold the macro enabled until the last read's data is compared.
               if (drain_cnt_reg == DRAIN_LAST) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  en_reg    <= 1'b0;
                  bm_reg    <= '0;
               end else begin
                  drain_cnt_reg <= drain_cnt_reg + 2'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   sram_bist_chk #(
      .P_ADDR_WIDTH (P_ADDR_WIDTH),
      .P_DATA_WIDTH (P_DATA_WIDTH),
      .P_RD_LAT     (P_RD_LAT)
   ) u_chk (
      .A_CLK     (A_CLK),
      .A_RESET_N (A_RESET_N),
      .clr       (go),
      .rd_vld    (ren_reg),
      .rd_exp    (din_reg),
      .rd_addr   (addr_reg),
      .rd_elem   (elem_reg),
      .rd_data   (A_DOUT),
      .fail      (A_FAIL),
      .fail_addr (A_FAIL_ADDR),
      .fail_elem (A_FAIL_ELEM),
      .fail_bits (A_FAIL_BITS),
      .err_cnt   (A_ERR_CNT)
   );

   assign A_BUSY      = busy_reg;
   assign A_DONE      = done_reg;
   assign A_BIST_EN   = en_reg;
   assign A_BIST_MEN  = en_reg;
   assign A_BIST_WEN  = wen_reg;
   assign A_BIST_REN  = ren_reg;
   assign A_BIST_ADDR = addr_reg;
   assign A_BIST_DIN  = din_reg;
   assign A_BIST_BM   = bm_reg;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for sram_march_bist_ctrl: three instances (read latency 1..3) on
// behavioural macros; instance 0 carries injectable stuck-at faults.
module tb_sram_march_bist_ctrl;

   localparam int AW   = 4;
   localparam int DW   = 8;
   localparam int N    = 1 << AW;
   localparam int MAXC = 2000;

   // March C- as written in the algorithm: direction, read value, write value (-1 = none).
   localparam int M_DOWN [6] = '{0, 0, 0, 1, 1, 0};
   localparam int M_RD   [6] = '{-1, 0, 1, 0, 1, 0};
   localparam int M_WR   [6] = '{0, 1, 0, 1, 0, -1};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start     [3];
   logic          busy      [3];
   logic          done      [3];
   logic          fail      [3];
   logic [AW-1:0] fail_addr [3];
   logic [2:0]    fail_elem [3];
   logic [DW-1:0] fail_bits [3];
   logic [7:0]    err_cnt   [3];
   logic          en        [3];
   logic          men       [3];
   logic          wen       [3];
   logic          ren       [3];
   logic [AW-1:0] addr      [3];
   logic [DW-1:0] din       [3];
   logic [DW-1:0] bm        [3];
   logic [DW-1:0] dout      [3];

   logic [DW-1:0] mem   [3][N];
   logic [DW-1:0] rpipe [3][3];
   logic [DW-1:0] sa0   [N];
   logic [DW-1:0] sa1   [N];

   int n_checks = 0;
   int n_fails  = 0;
   int mon_wr   = 0;
   int mon_rd   = 0;
   int mon_both = 0;
   int mon_busy = 0;

   logic          exp_fail;
   logic [AW-1:0] exp_addr;
   logic [2:0]    exp_elem;
   logic [DW-1:0] exp_bits;
   int            exp_err;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      sram_march_bist_ctrl #(
         .P_ADDR_WIDTH (AW),
         .P_DATA_WIDTH (DW),
         .P_RD_LAT     (gi + 1)
      ) u_dut (
         .A_CLK       (clk),
         .A_RESET_N   (rst_n),
         .A_START     (start[gi]),
         .A_BUSY      (busy[gi]),
         .A_DONE      (done[gi]),
         .A_FAIL      (fail[gi]),
         .A_FAIL_ADDR (fail_addr[gi]),
         .A_FAIL_ELEM (fail_elem[gi]),
         .A_FAIL_BITS (fail_bits[gi]),
         .A_ERR_CNT   (err_cnt[gi]),
         .A_BIST_EN   (en[gi]),
         .A_BIST_MEN  (men[gi]),
         .A_BIST_WEN  (wen[gi]),
         .A_BIST_REN  (ren[gi]),
         .A_BIST_ADDR (addr[gi]),
         .A_BIST_DIN  (din[gi]),
         .A_BIST_BM   (bm[gi]),
         .A_DOUT      (dout[gi])
      );
      assign dout[gi] = rpipe[gi][gi];
   end

   // Behavioural macros; only instance 0 sees the stuck-at masks.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (en[d] && men[d] && wen[d])
            mem[d][addr[d]] <= (mem[d][addr[d]] & ~bm[d]) | (din[d] & bm[d]);
         if (en[d] && men[d] && ren[d])
            rpipe[d][0] <= (d == 0) ? ((mem[d][addr[d]] & ~sa0[addr[d]]) | sa1[addr[d]])
                                    : mem[d][addr[d]];
         rpipe[d][1] <= rpipe[d][0];
         rpipe[d][2] <= rpipe[d][1];
      end
   end

   // Command-stream monitor for instance 0, restarted on an accepted START.
   always @(posedge clk) begin
      if (start[0] && !busy[0]) begin
         mon_wr <= 0; mon_rd <= 0; mon_both <= 0; mon_busy <= 0;
      end else if (busy[0]) begin
         mon_wr   <= mon_wr + int'(wen[0] && !ren[0]);
         mon_rd   <= mon_rd + int'(ren[0] && !wen[0]);
         mon_both <= mon_both + int'(wen[0] && ren[0]);
         mon_busy <= mon_busy + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] outs0();
      return 64'({busy[0], done[0], fail[0], fail_addr[0], fail_elem[0], fail_bits[0],
                  err_cnt[0], en[0], men[0], wen[0], ren[0], addr[0], din[0], bm[0]});
   endfunction

   task automatic clear_faults();
      for (int i = 0; i < N; i++) begin
         sa0[i] = '0;
         sa1[i] = '0;
      end
   endtask

   // Runs the whole algorithm on a plain array with the fault masks applied to reads.
   task automatic model_march();
      logic [DW-1:0] m [N];
      logic [DW-1:0] got;
      logic [DW-1:0] want;
      int a;
      exp_fail = 1'b0; exp_addr = '0; exp_elem = '0; exp_bits = '0; exp_err = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            a = (M_DOWN[e] != 0) ? N - 1 - i : i;
            if (M_RD[e] >= 0) begin
               got  = (m[a] & ~sa0[a]) | sa1[a];
               want = (M_RD[e] == 1) ? '1 : '0;
               if (got !== want) begin
                  if (!exp_fail) begin
                     exp_addr = AW'(a);
                     exp_elem = 3'(e);
                     exp_bits = got ^ want;
                  end
                  exp_fail = 1'b1;
                  if (exp_err < 255) exp_err++;
               end
            end
            if (M_WR[e] >= 0) m[a] = (M_WR[e] == 1) ? '1 : '0;
         end
      end
   endtask

   // Returns one #1 after the edge that samples START, i.e. in cycle 1.
   task automatic start_pulse(input int d);
      @(negedge clk);
      start[d] = 1'b1;
      @(posedge clk);
      #1;
      start[d] = 1'b0;
   endtask

   // cyc is the cycle in which DONE is first seen (cycle 1 follows the START edge).
   task automatic wait_done(input int d, input bit glitch, output int cyc);
      cyc = 1;
      while (done[d] !== 1'b1 && cyc < MAXC) begin
         @(posedge clk);
         #1;
         cyc++;
         start[d] = glitch && (cyc == 10 || cyc == 100);
      end
      start[d] = 1'b0;
      check("done_seen", 64'(done[d]), 64'(1));
   endtask

   task automatic check_result(input string tag);
      check({tag, "_fail"},      64'(fail[0]),      64'(exp_fail));
      check({tag, "_fail_addr"}, 64'(fail_addr[0]), 64'(exp_addr));
      check({tag, "_fail_elem"}, 64'(fail_elem[0]), 64'(exp_elem));
      check({tag, "_fail_bits"}, 64'(fail_bits[0]), 64'(exp_bits));
      check({tag, "_err_cnt"},   64'(err_cnt[0]),   64'(exp_err));
   endtask

   initial begin
      int cyc;
      int nf;
      int fa;
      logic [DW-1:0] fbits;

      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) start[d] = 1'b0;
      clear_faults();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs0", outs0(), 64'(0));
      check("reset_busy1", 64'(busy[1]), 64'(0));
      check("reset_done2", 64'(done[2]), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Clean run, latency 1: first command, completion cycle, command mix.
      start_pulse(0);
      check("first_wen",  64'(wen[0]),  64'(1));
      check("first_ren",  64'(ren[0]),  64'(0));
      check("first_addr", 64'(addr[0]), 64'(0));
      check("first_din",  64'(din[0]),  64'(0));
      check("first_en",   64'(en[0] && men[0]), 64'(1));
      check("first_bm",   64'(bm[0]),   64'(8'hFF));
      check("first_busy", 64'(busy[0]), 64'(1));
      wait_done(0, 1'b0, cyc);
      $display("run clean lat1: done cycle %0d fail %0d err %0d", cyc, fail[0], err_cnt[0]);
      check("clean_done_cycle", 64'(cyc), 64'(10 * N + 1 + 1));
      check("clean_busy_low",   64'(busy[0]), 64'(0));
      check("clean_fail",       64'(fail[0]), 64'(0));
      check("clean_err",        64'(err_cnt[0]), 64'(0));
      check("clean_writes",     64'(mon_wr), 64'(5 * N));
      check("clean_reads",      64'(mon_rd), 64'(5 * N));
      check("clean_both",       64'(mon_both), 64'(0));
      check("clean_busy_cyc",   64'(mon_busy), 64'(10 * N + 1));
      check("done_ctrl_idle",   64'({en[0], men[0], wen[0], ren[0], bm[0]}), 64'(0));

      // Stuck-at-1 on bit 3 at address 5.
      sa1[5] = 8'h08;
      model_march();
      start_pulse(0);
      wait_done(0, 1'b0, cyc);
      $display("run sa1 a5 b3: fail %0d addr %0d elem %0d bits %0h err %0d",
               fail[0], fail_addr[0], fail_elem[0], fail_bits[0], err_cnt[0]);
      check_result("sa1_a5");
      check("sa1_a5_addr_const", 64'(fail_addr[0]), 64'(5));
      check("sa1_a5_elem_const", 64'(fail_elem[0]), 64'(1));
      check("sa1_a5_bits_const", 64'(fail_bits[0]), 64'(8'h08));
      check("sa1_a5_err_const",  64'(err_cnt[0]), 64'(3));

      // Restart from DONE after a failed run clears status at the START edge.
      clear_faults();
      start_pulse(0);
      check("restart_fail_clr", 64'(fail[0]), 64'(0));
      check("restart_err_clr",  64'(err_cnt[0]), 64'(0));
      check("restart_info_clr", 64'({fail_addr[0], fail_elem[0], fail_bits[0]}), 64'(0));
      check("restart_done_clr", 64'(done[0]), 64'(0));
      wait_done(0, 1'b0, cyc);
      $display("run restart clean: done cycle %0d fail %0d", cyc, fail[0]);
      check("restart_pass", 64'({fail[0], err_cnt[0]}), 64'(0));

      // START pulses while busy are ignored.
      start_pulse(0);
      wait_done(0, 1'b1, cyc);
      $display("run with busy starts: done cycle %0d", cyc);
      check("glitch_done_cycle", 64'(cyc), 64'(10 * N + 1 + 1));
      check("glitch_busy_cyc",   64'(mon_busy), 64'(10 * N + 1));
      check("glitch_fail",       64'(fail[0]), 64'(0));

      // Random stuck-at faults against the array model.
      for (int it = 0; it < 6; it++) begin
         clear_faults();
         nf = (it == 0) ? 0 : int'($urandom_range(1, 3));
         for (int k = 0; k < nf; k++) begin
            fa    = int'($urandom_range(0, N - 1));
            fbits = DW'($urandom_range(1, 255));
            if ($urandom_range(0, 1) == 1) sa1[fa] = sa1[fa] | fbits;
            else                           sa0[fa] = sa0[fa] | fbits;
         end
         model_march();
         start_pulse(0);
         wait_done(0, ($urandom_range(0, 1) == 1), cyc);
         $display("run random %0d: faults %0d fail %0d addr %0d elem %0d bits %0h err %0d",
                  it, nf, fail[0], fail_addr[0], fail_elem[0], fail_bits[0], err_cnt[0]);
         check_result("rand");
         check("rand_done_cycle", 64'(cyc), 64'(10 * N + 1 + 1));
      end
      clear_faults();

      // Read latency 2 and 3 on clean macros.
      for (int d = 1; d < 3; d++) begin
         start_pulse(d);
         wait_done(d, 1'b0, cyc);
         $display("run clean lat%0d: done cycle %0d fail %0d err %0d", d + 1, cyc, fail[d], err_cnt[d]);
         check("lat_done_cycle", 64'(cyc), 64'(10 * N + (d + 1) + 1));
         check("lat_pass",       64'({fail[d], err_cnt[d]}), 64'(0));
         check("lat_busy_low",   64'(busy[d]), 64'(0));
      end

      // Asynchronous reset in cycle 50, then a full clean rerun.
      start_pulse(0);
      repeat (49) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      $display("reset in cycle 50: outputs %0h", outs0());
      check("midrst_outs0", outs0(), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_no_done", 64'({done[0], busy[0]}), 64'(0));
      start_pulse(0);
      wait_done(0, 1'b0, cyc);
      $display("run after reset: done cycle %0d fail %0d", cyc, fail[0]);
      check("midrst_done_cycle", 64'(cyc), 64'(10 * N + 1 + 1));
      check("midrst_pass",       64'({fail[0], err_cnt[0]}), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
